relu_maxpool1: RTL and testbench

- Streaming stage directly downstream of the layer-1 convolution array.
- Takes the raw 55x55x96 signed conv output, applies ReLU and 3x3 stride-2 max-pooling, and emits 27x27x96 to the layer-2 input buffer.
- Consumes one 16-bit element per beat, channel-plane-major and raster order within a plane.
- Uses a single 27-entry partial-max row buffer plus a horizontal partial register instead of full line buffers.

---
 rtl/relu_maxpool1.sv | 102 ++++++++++
 tb/tb_relu_maxpool1.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool1.sv
`timescale 1ns/1ps
// relu_maxpool1: ReLU plus 3x3 stride-2 max-pool over a raster-streamed, plane-major conv output.
// Keeps a row of vertical partial maxima and a single horizontal partial register instead of line buffers.
module relu_maxpool1 #(
    parameter int DW      = 16,
    parameter int IN_DIM  = 55,
    parameter int CH      = 96,
    parameter int RELU_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          frame_err
);
    localparam int OUT_DIM = (IN_DIM - 3) / 2 + 1;
    localparam int CW      = $clog2(IN_DIM + 1);
    localparam int PW      = $clog2(CH + 1);
    localparam int KW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    logic [CW-1:0]        col, row;
    logic [PW-1:0]        plane;
    logic [KW-1:0]        k;
    logic signed [DW-1:0] x, hr, hmax, acc_rd, result;
    logic signed [DW-1:0] acc [OUT_DIM];
    logic                 accept, hwin, emit;
    logic                 col_end, row_end, plane_end, last_pos;

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] relu(input logic signed [DW-1:0] v);
        return (RELU_EN != 0 && v < 0) ? '0 : v;
    endfunction

    assign in_ready  = ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;
    assign x         = in_data;

    assign col_end   = (col == CW'(IN_DIM - 1));
    assign row_end   = (row == CW'(IN_DIM - 1));
    assign plane_end = (plane == PW'(CH - 1));
    assign last_pos  = plane_end & row_end & col_end;

    // A horizontal window closes on every even column > 0; window k = col/2 - 1.
    assign hwin      = (col != '0) & ~col[0];
    assign emit      = accept & hwin & (row != '0) & ~row[0];
    assign k         = KW'((col >> 1) - CW'(1));

    assign hmax      = smax(hr, x);
    assign acc_rd    = acc[k];
    assign result    = smax(acc_rd, hmax);

    // Control: position counters, framing check and the single-entry output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            plane     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            frame_err <= 1'b0;
        end else begin
            if (accept) begin
                col <= col_end ? '0 : col + CW'(1);
                if (col_end) begin
                    row <= row_end ? '0 : row + CW'(1);
                    if (row_end)
                        plane <= plane_end ? '0 : plane + PW'(1);
                end
                if (in_last != last_pos)
                    frame_err <= 1'b1;
            end
            if (emit) begin
                out_data  <= relu(result);
                out_valid <= 1'b1;
                out_last  <= last_pos;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // Datapath: the row that closes a window also reseeds its column entry for the next window row.
    always_ff @(posedge clk) begin
        if (accept) begin
            hr <= (col != '0 && col[0]) ? hmax : x;
            if (hwin)
                acc[k] <= (row != '0 && row[0]) ? result : hmax;
        end
    end
endmodule

// File: tb/tb_relu_maxpool1.sv
`timescale 1ns/1ps
// Directed bench for relu_maxpool1: small-plane instances plus one default-size instance for framing.
module tb_relu_maxpool1;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] in_data [5];
    logic [15:0] out_data [5];
    logic        in_valid [5];
    logic        in_ready [5];
    logic        in_last [5];
    logic        out_valid [5];
    logic        out_ready [5];
    logic        out_last [5];
    logic        frame_err [5];

    int total = 0;
    int bad   = 0;

    logic [16:0] oq0[$], oq1[$], oq2[$], oq4[$], exq[$];
    logic signed [15:0] gin [2][9][9];
    logic [16:0] held;
    logic        held_v = 1'b0;
    logic        stall_done;

    relu_maxpool1 #(.DW(16), .IN_DIM(5), .CH(1), .RELU_EN(1)) u_a (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_last(in_last[0]), .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_last(out_last[0]), .frame_err(frame_err[0]));
    relu_maxpool1 #(.DW(16), .IN_DIM(5), .CH(1), .RELU_EN(0)) u_b (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_last(in_last[1]), .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_last(out_last[1]), .frame_err(frame_err[1]));
    relu_maxpool1 #(.DW(16), .IN_DIM(5), .CH(2), .RELU_EN(1)) u_c (
        .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_last(in_last[2]), .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_last(out_last[2]), .frame_err(frame_err[2]));
    relu_maxpool1 u_d (
        .clk(clk), .rst(rst), .in_data(in_data[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_last(in_last[3]), .out_data(out_data[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .out_last(out_last[3]), .frame_err(frame_err[3]));
    relu_maxpool1 #(.DW(16), .IN_DIM(9), .CH(2), .RELU_EN(1)) u_e (
        .clk(clk), .rst(rst), .in_data(in_data[4]), .in_valid(in_valid[4]), .in_ready(in_ready[4]),
        .in_last(in_last[4]), .out_data(out_data[4]), .out_valid(out_valid[4]), .out_ready(out_ready[4]),
        .out_last(out_last[4]), .frame_err(frame_err[4]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Outputs are captured at the falling edge when a pop will happen on the next rising edge.
    always @(negedge clk) begin
        if (out_valid[0] && out_ready[0]) oq0.push_back({out_last[0], out_data[0]});
        if (out_valid[1] && out_ready[1]) oq1.push_back({out_last[1], out_data[1]});
        if (out_valid[2] && out_ready[2]) oq2.push_back({out_last[2], out_data[2]});
        if (out_valid[4] && out_ready[4]) oq4.push_back({out_last[4], out_data[4]});
        if (held_v) begin
            chk("stall_valid", 32'(out_valid[4]), 32'd1);
            chk("stall_hold", 32'({out_last[4], out_data[4]}), 32'(held));
        end
        held_v = out_valid[4] && !out_ready[4];
        held   = {out_last[4], out_data[4]};
    end

    task automatic send(input int id, input logic [15:0] d, input logic last);
        int guard;
        guard = 0;
        in_data[id]  = d;
        in_valid[id] = 1'b1;
        in_last[id]  = last;
        forever begin
            @(negedge clk);
            if (in_ready[id]) break;
            guard++;
            if (guard > 1000) begin
                $display("FAIL send_timeout: in_ready stuck low on dut %0d", id);
                $fatal(1, "in_ready timeout");
            end
        end
        @(posedge clk);
        #1;
        in_valid[id] = 1'b0;
        in_last[id]  = 1'b0;
    endtask

    task automatic cmp_q(input string tag, input int id);
        logic [16:0] q[$];
        case (id)
            0:       q = oq0;
            1:       q = oq1;
            2:       q = oq2;
            default: q = oq4;
        endcase
        chk({tag, "_count"}, 32'(q.size()), 32'(exq.size()));
        for (int i = 0; i < exq.size() && i < q.size(); i++)
            chk(tag, 32'(q[i]), 32'(exq[i]));
    endtask

    task automatic clr();
        oq0.delete(); oq1.delete(); oq2.delete(); oq4.delete(); exq.delete();
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic ramp_exp();
        exq.delete();
        exq.push_back({1'b0, 16'd12});
        exq.push_back({1'b0, 16'd14});
        exq.push_back({1'b0, 16'd22});
        exq.push_back({1'b1, 16'd24});
    endtask

    task automatic run_random();
        logic [15:0]        v;
        logic signed [15:0] m;
        stall_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 2; p++)
                    for (int r = 0; r < 9; r++)
                        for (int c = 0; c < 9; c++) begin
                            v = 16'($urandom);
                            gin[p][r][c] = v;
                            send(4, v, p == 1 && r == 8 && c == 8);
                        end
                stall_done = 1'b1;
            end
            begin
                while (!stall_done) begin
                    @(posedge clk);
                    #1;
                    out_ready[4] = ($urandom_range(0, 99) >= 30);
                end
            end
        join
        out_ready[4] = 1'b1;
        for (int i = 0; i < 50 && out_valid[4]; i++) begin
            @(posedge clk);
            #1;
        end
        drain();
        chk("rand_drained", 32'(out_valid[4]), 32'd0);
        exq.delete();
        for (int p = 0; p < 2; p++)
            for (int orow = 0; orow < 4; orow++)
                for (int ocol = 0; ocol < 4; ocol++) begin
                    m = gin[p][2*orow][2*ocol];
                    for (int dr = 0; dr < 3; dr++)
                        for (int dc = 0; dc < 3; dc++)
                            if (gin[p][2*orow+dr][2*ocol+dc] > m) m = gin[p][2*orow+dr][2*ocol+dc];
                    exq.push_back({p == 1 && orow == 3 && ocol == 3, (m < 0) ? 16'h0000 : 16'(m)});
                end
        cmp_q("rand", 4);
        chk("rand_ferr", 32'(frame_err[4]), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data[i] = '0; in_valid[i] = 1'b0; in_last[i] = 1'b0; out_ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_out_data", 32'(out_data[0]), 32'd0);
        chk("rst_out_last", 32'(out_last[0]), 32'd0);
        chk("rst_frame_err", 32'(frame_err[0]), 32'd0);
        chk("rst_in_ready", 32'(in_ready[0]), 32'd1);
        rst = 1'b0;

        // Ramp: output one cycle after the closing beat of each window.
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                send(0, 16'(r*5 + c), r == 4 && c == 4);
                chk("ramp_latency", 32'(out_valid[0]), 32'(r > 0 && r % 2 == 0 && c > 0 && c % 2 == 0));
            end
        drain();
        ramp_exp();
        cmp_q("ramp", 0);
        chk("ramp_ferr", 32'(frame_err[0]), 32'd0);

        // All -7: clamped with ReLU, signed max preserved without.
        clr();
        for (int i = 0; i < 25; i++) send(0, 16'hFFF9, i == 24);
        for (int i = 0; i < 25; i++) send(1, 16'hFFF9, i == 24);
        drain();
        for (int i = 0; i < 4; i++) exq.push_back({i == 3, 16'h0000});
        cmp_q("neg_relu", 0);
        exq.delete();
        for (int i = 0; i < 4; i++) exq.push_back({i == 3, 16'hFFF9});
        cmp_q("neg_norelu", 1);

        // Two planes.
        clr();
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    send(2, 16'(p*100 + r*5 + c), p == 1 && r == 4 && c == 4);
        drain();
        foreach (exq[i]) exq.delete(i);
        for (int p = 0; p < 2; p++)
            for (int r = 2; r <= 4; r += 2)
                for (int c = 2; c <= 4; c += 2)
                    exq.push_back({p == 1 && r == 4 && c == 4, 16'(p*100 + r*5 + c)});
        cmp_q("planes", 2);
        chk("planes_ferr", 32'(frame_err[2]), 32'd0);

        clr();
        run_random();

        // Framing error on default-size instance.
        for (int i = 0; i < 1000; i++) begin
            send(3, 16'(i), i == 999);
            if (i == 998) chk("ferr_before", 32'(frame_err[3]), 32'd0);
        end
        chk("ferr_rise", 32'(frame_err[3]), 32'd1);
        for (int i = 0; i < 20; i++) send(3, 16'(i), 1'b0);
        chk("ferr_sticky", 32'(frame_err[3]), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("ferr_cleared", 32'(frame_err[3]), 32'd0);

        // Reset mid-plane with a pending output.
        clr();
        for (int i = 0; i < 13; i++) send(0, 16'(i), 1'b0);
        chk("pre_rst_valid", 32'(out_valid[0]), 32'd1);
        out_ready[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_drop_valid", 32'(out_valid[0]), 32'd0);
        rst = 1'b0;
        out_ready[0] = 1'b1;
        clr();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                send(0, 16'(r*5 + c), r == 4 && c == 4);
        drain();
        ramp_exp();
        cmp_q("post_rst", 0);
        chk("post_rst_ferr", 32'(frame_err[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
